// File: rtl/mandel_iterator_if.sv
// mandel_iterator_if: start/done handshake and result bundle between the
// point dispatcher and the escape-time engine.
interface mandel_iterator_if #(
  parameter int ITER_W = 16
);
  logic              start;
  logic [31:0]       c_re;
  logic [31:0]       c_im;
  logic [ITER_W-1:0] max_iter;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_count;
  logic              escaped;

  modport master (
    output start, c_re, c_im, max_iter,
    input  busy, done, iter_count, escaped
  );

  modport slave (
    input  start, c_re, c_im, max_iter,
    output busy, done, iter_count, escaped
  );
endinterface

// File: rtl/mandel_iterator.sv
// mandel_iterator: one-point Mandelbrot escape-time engine, one step/clock.
// Define MANDEL_ABORT_EN to add the abort port.
module mandel_iterator #(
  parameter int FRAC_BITS = 28,
  parameter int ITER_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  mandel_iterator_if.slave bus,
  output logic [31:0] z_re,
  output logic [31:0] z_im,
  input  logic [31:0] gen_aa_minus_bb,
  input  logic [31:0] gen_two_ab,
  input  logic [31:0] gen_aa_plus_bb
`ifdef MANDEL_ABORT_EN
  ,
  input  logic        abort
`endif
);

  localparam logic [31:0] TWO  = 32'(64'd2 << FRAC_BITS);
  localparam logic [31:0] FOUR = 32'(64'd4 << FRAC_BITS);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [31:0]       c_re_q;
  logic [31:0]       c_im_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] n;
  logic [ITER_W-1:0] cnt_q;
  logic              esc_q;
  logic [31:0]       abs_re;
  logic [31:0]       abs_im;
  logic              esc_hit;
  logic              lim_hit;
  logic              kill;

`ifdef MANDEL_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Magnitudes compared unsigned so 0x8000_0000 still counts as escaped.
  assign abs_re  = z_re[31] ? (~z_re + 32'd1) : z_re;
  assign abs_im  = z_im[31] ? (~z_im + 32'd1) : z_im;
  assign esc_hit = (abs_re > TWO) | (abs_im > TWO)
                 | (gen_aa_plus_bb > FOUR);
  assign lim_hit = (n == max_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = ITER;
      ITER: begin
        if (kill)                   state_nx = IDLE;
        else if (esc_hit | lim_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      ITER: bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_re_q <= '0;
      c_im_q <= '0;
      max_q  <= '0;
      n      <= '0;
      z_re   <= '0;
      z_im   <= '0;
      cnt_q  <= '0;
      esc_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            c_re_q <= bus.c_re;
            c_im_q <= bus.c_im;
            max_q  <= bus.max_iter;
            n      <= '0;
            z_re   <= '0;
            z_im   <= '0;
          end
        end
        ITER: begin
          if (!kill) begin
            if (esc_hit) begin
              esc_q <= 1'b1;
              cnt_q <= n;
            end else if (lim_hit) begin
              esc_q <= 1'b0;
              cnt_q <= n;
            end else begin
              z_re <= gen_aa_minus_bb + c_re_q;
              z_im <= gen_two_ab + c_im_q;
              n    <= n + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.iter_count = cnt_q;
  assign bus.escaped    = esc_q;

endmodule

// File: tb/tb_mandel_iterator.sv
// tb_mandel_iterator: randomized and directed points against an in-bench
// trajectory model of the escape-time iteration.
module tb_mandel_iterator;

  localparam longint TWO  = 64'h2000_0000;
  localparam longint FOUR = 64'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mandel_iterator_if #(.ITER_W(16)) bus();

  logic [31:0] z_re;
  logic [31:0] z_im;
  logic [31:0] g_amb;
  logic [31:0] g_tab;
  logic [31:0] g_apb;
  logic        abort;
  longint      ga;
  longint      gb;

  mandel_iterator dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .z_re            (z_re),
    .z_im            (z_im),
    .gen_aa_minus_bb (g_amb),
    .gen_two_ab      (g_tab),
    .gen_aa_plus_bb  (g_apb)
`ifdef MANDEL_ABORT_EN
    ,
    .abort           (abort)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  function automatic longint sq(longint x);
    return (x * x) >>> 28;
  endfunction

  function automatic longint tw(longint x, longint y);
    return (2 * x * y) >>> 28;
  endfunction

  // Square/product generator stage
  always_comb begin
    ga    = longint'($signed(z_re));
    gb    = longint'($signed(z_im));
    g_amb = 32'(sq(ga) - sq(gb));
    g_tab = 32'(tw(ga, gb));
    g_apb = 32'(sq(ga) + sq(gb));
  end

  bit          m_active;
  int          m_t;
  int          m_cnt;
  bit          m_esc;
  logic [31:0] m_tre[$];
  logic [31:0] m_tim[$];
  logic [31:0] h_cnt;
  bit          h_esc;
  logic [31:0] h_re;
  logic [31:0] h_im;
  bit          chk_on;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Whole-point trajectory: z at each evaluated iteration, plus outcome.
  task automatic model_point(input logic [31:0] cr, input logic [31:0] ci,
                             input int mx);
    longint zr;
    longint zi;
    longint aa;
    longint bb;
    longint nr;
    zr = 0;
    zi = 0;
    m_tre.delete();
    m_tim.delete();
    for (int k = 0; k <= mx; k++) begin
      m_tre.push_back(32'(zr));
      m_tim.push_back(32'(zi));
      aa = sq(zr);
      bb = sq(zi);
      if ((zr < 0 ? -zr : zr) > TWO || (zi < 0 ? -zi : zi) > TWO
          || aa + bb > FOUR) begin
        m_cnt = k;
        m_esc = 1'b1;
        return;
      end
      if (k == mx) begin
        m_cnt = k;
        m_esc = 1'b0;
        return;
      end
      nr = longint'($signed(32'(aa - bb + longint'($signed(cr)))));
      zi = longint'($signed(32'(tw(zr, zi) + longint'($signed(ci)))));
      zr = nr;
    end
  endtask

  logic [31:0] e_re;
  logic [31:0] e_im;
  logic [31:0] e_cnt;
  bit          e_busy;
  bit          e_done;
  bit          e_esc;

  always @(negedge clk) begin
    if (chk_on) begin
      if (m_active && m_t <= m_cnt) begin
        e_busy = 1'b1;
        e_done = 1'b0;
        e_re   = m_tre[m_t];
        e_im   = m_tim[m_t];
        e_cnt  = h_cnt;
        e_esc  = h_esc;
      end else if (m_active) begin
        e_busy = 1'b1;
        e_done = 1'b1;
        e_re   = m_tre[m_cnt];
        e_im   = m_tim[m_cnt];
        e_cnt  = 32'(m_cnt);
        e_esc  = m_esc;
      end else begin
        e_busy = 1'b0;
        e_done = 1'b0;
        e_re   = h_re;
        e_im   = h_im;
        e_cnt  = h_cnt;
        e_esc  = h_esc;
      end
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("iter_count", 32'(bus.iter_count), e_cnt);
      chk("escaped", 32'(bus.escaped), 32'(e_esc));
      chk("z_re", z_re, e_re);
      chk("z_im", z_im, e_im);
      if (m_active) begin
        if (m_t == m_cnt + 1) begin
          h_cnt    = 32'(m_cnt);
          h_esc    = m_esc;
          h_re     = m_tre[m_cnt];
          h_im     = m_tim[m_cnt];
          m_active = 1'b0;
        end
        m_t++;
      end
    end
  end

  task automatic start_point(input logic [31:0] cr, input logic [31:0] ci,
                             input int mx);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.c_re     = cr;
    bus.c_im     = ci;
    bus.max_iter = 16'(mx);
    model_point(cr, ci, mx);
    @(posedge clk);
    m_t      = 0;
    m_active = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 70000 && m_active; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk_held(input string nm, input int cnt, input bit esc);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_cnt"}, 32'(bus.iter_count), 32'(cnt));
    chk({nm, "_esc"}, 32'(bus.escaped), 32'(esc));
  endtask

  logic [31:0] rc_re;
  logic [31:0] rc_im;

  initial begin
    bus.start    = 1'b0;
    bus.c_re     = '0;
    bus.c_im     = '0;
    bus.max_iter = '0;
    abort        = 1'b0;
    m_active     = 1'b0;
    m_t          = 0;
    m_cnt        = 0;
    m_esc        = 1'b0;
    h_cnt        = '0;
    h_esc        = 1'b0;
    h_re         = '0;
    h_im         = '0;
    chk_on       = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cnt", 32'(bus.iter_count), 32'd0);
    chk("rst_esc", 32'(bus.escaped), 32'd0);
    chk("rst_z_re", z_re, 32'd0);
    chk("rst_z_im", z_im, 32'd0);
    chk_on = 1'b1;

    start_point(32'h0, 32'h0, 100);
    wait_idle();
    chk("pin_origin_model", 32'(m_cnt), 32'd100);
    chk_held("origin", 100, 1'b0);
    chk("origin_z", z_re, 32'h0);

    start_point(32'h1000_0000, 32'h0, 50);
    wait_idle();
    chk("pin_one_model", 32'(m_cnt), 32'd3);
    chk_held("one", 3, 1'b1);
    chk("one_z", z_re, 32'h5000_0000);

    start_point(32'hE000_0000, 32'h0, 20);
    wait_idle();
    chk("pin_m2_model", 32'(m_esc), 32'd0);
    chk_held("m2", 20, 1'b0);
    chk("m2_z", z_re, 32'h2000_0000);

    start_point(32'h0, 32'h1000_0000, 30);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.c_re  = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && m_active && m_t != m_cnt + 1; i++)
      @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_held("i", 30, 1'b0);
    chk("i_z_re", z_re, 32'hF000_0000);
    chk("i_z_im", z_im, 32'h1000_0000);

    start_point(32'h0, 32'h0, 100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    m_active = 1'b0;
    h_cnt    = '0;
    h_esc    = 1'b0;
    h_re     = '0;
    h_im     = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_held("rst_mid", 0, 1'b0);
    chk("rst_mid_done", 32'(bus.done), 32'd0);
    start_point(32'h0, 32'h0, 0);
    wait_idle();
    chk_held("max0", 0, 1'b0);

`ifdef MANDEL_ABORT_EN
    start_point(32'h1000_0000, 32'h0, 50);
    wait_idle();
    start_point(32'h0, 32'h0, 100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    m_active = 1'b0;
    h_re     = m_tre[m_t - 1];
    h_im     = m_tim[m_t - 1];
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk_held("abort", 3, 1'b1);
`endif

    for (int p = 0; p < 25; p++) begin
      rc_re = 32'($urandom_range(32'h4000_0000, 0)) - 32'h2000_0000;
      rc_im = 32'($urandom_range(32'h4000_0000, 0)) - 32'h2000_0000;
      start_point(rc_re, rc_im, int'($urandom_range(40, 0)));
      wait_idle();
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
